// File: rtl/fu_branch_pipe.sv
// Pipelined branch/jump resolution unit: decodes and resolves one op per cycle
// into a single held result stage, with age-based flush and saturating stats.
module fu_branch_pipe #(
  parameter int XLEN      = 32,
  parameter int ROB_DEPTH = 32,
  parameter int TAG_W     = 5,
  parameter int PREG_W    = 7,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_func3,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic [PREG_W-1:0] in_pd,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  input  logic [XLEN-1:0]   ps1_data,
  input  logic [XLEN-1:0]   ps2_data,
  input  logic [TAG_W-1:0]  rob_head,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_rob_tag,
  output logic [PREG_W-1:0] out_pd,
  output logic              out_wb_en,
  output logic [XLEN-1:0]   out_data,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [XLEN-1:0]   out_redirect_pc,
  output logic [CNT_W-1:0]  cnt_branches,
  output logic [CNT_W-1:0]  cnt_mispredicts
);

  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       OP_JAL    = 7'b1101111;
  localparam logic [6:0]       OP_JALR   = 7'b1100111;
  localparam logic [TAG_W-1:0] AGE_MASK  = TAG_W'(ROB_DEPTH - 1);

  // Distance from the ROB head; larger means younger.
  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] tag,
                                              input logic [TAG_W-1:0] head);
    return (tag - head) & AGE_MASK;
  endfunction

  // Held result stage
  logic              out_valid_reg;
  logic              out_valid_next;
  logic [TAG_W-1:0]  out_rob_tag_reg;
  logic [PREG_W-1:0] out_pd_reg;
  logic              out_wb_en_reg;
  logic [XLEN-1:0]   out_data_reg;
  logic              out_taken_reg;
  logic              out_mispredict_reg;
  logic [XLEN-1:0]   out_redirect_pc_reg;
  logic              out_counted_reg;

  // Resolution of the incoming op
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] rs_sum;
  logic            op_eq;
  logic            op_lt;
  logic            op_ltu;
  logic            br_cond;
  logic            br_func_ok;
  logic            res_known;
  logic            res_taken;
  logic            res_wb_en;
  logic [XLEN-1:0] res_target;
  logic            res_mispredict;
  logic [XLEN-1:0] res_redirect;

  always_comb begin
    pc_plus4 = in_pc + XLEN'(4);
    pc_sum   = in_pc + in_imm;
    rs_sum   = ps1_data + in_imm;
    op_eq    = (ps1_data == ps2_data);
    op_lt    = ($signed(ps1_data) < $signed(ps2_data));
    op_ltu   = (ps1_data < ps2_data);

    br_cond    = 1'b0;
    br_func_ok = 1'b1;
    case (in_func3)
      3'b000:  br_cond = op_eq;
      3'b001:  br_cond = !op_eq;
      3'b100:  br_cond = op_lt;
      3'b101:  br_cond = !op_lt;
      3'b110:  br_cond = op_ltu;
      3'b111:  br_cond = !op_ltu;
      default: br_func_ok = 1'b0;
    endcase

    res_known  = 1'b0;
    res_taken  = 1'b0;
    res_wb_en  = 1'b0;
    res_target = pc_plus4;
    if (in_opcode == OP_BRANCH && br_func_ok) begin
      res_known  = 1'b1;
      res_taken  = br_cond;
      res_target = {pc_sum[XLEN-1:1], 1'b0};
    end else if (in_opcode == OP_JAL) begin
      res_known  = 1'b1;
      res_taken  = 1'b1;
      res_wb_en  = 1'b1;
      res_target = pc_sum;
    end else if (in_opcode == OP_JALR && in_func3 == 3'b000) begin
      res_known  = 1'b1;
      res_taken  = 1'b1;
      res_wb_en  = 1'b1;
      res_target = {rs_sum[XLEN-1:1], 1'b0};
    end

    // Unrecognised encodings never redirect, whatever the frontend guessed.
    res_mispredict = res_known &&
                     ((res_taken != in_pred_taken) ||
                      (res_taken && (res_target != in_pred_target)));
    res_redirect   = res_taken ? res_target : pc_plus4;
  end

  // Handshake and flush control
  logic kill_in;
  logic kill_held;
  logic accept;
  logic transfer;
  logic retire;

  always_comb begin
    kill_in   = flush_valid &&
                (age_of(in_rob_tag, rob_head) > age_of(flush_tag, rob_head));
    kill_held = flush_valid && out_valid_reg &&
                (age_of(out_rob_tag_reg, rob_head) > age_of(flush_tag, rob_head));
    in_ready  = !out_valid_reg || out_ready;
    accept    = in_valid && in_ready && !kill_in;
    transfer  = out_valid_reg && out_ready;
    // A beat that is flushed while being handed over is not a real retirement.
    retire    = transfer && !kill_held && out_counted_reg;

    if (accept) begin
      out_valid_next = 1'b1;
    end else if (transfer || kill_held) begin
      out_valid_next = 1'b0;
    end else begin
      out_valid_next = out_valid_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg       <= 1'b0;
      out_rob_tag_reg     <= '0;
      out_pd_reg          <= '0;
      out_wb_en_reg       <= 1'b0;
      out_data_reg        <= '0;
      out_taken_reg       <= 1'b0;
      out_mispredict_reg  <= 1'b0;
      out_redirect_pc_reg <= '0;
      out_counted_reg     <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      if (accept) begin
        out_rob_tag_reg     <= in_rob_tag;
        out_pd_reg          <= in_pd;
        out_wb_en_reg       <= res_wb_en;
        out_data_reg        <= pc_plus4;
        out_taken_reg       <= res_taken;
        out_mispredict_reg  <= res_mispredict;
        out_redirect_pc_reg <= res_redirect;
        out_counted_reg     <= res_known;
      end
    end
  end

  // Saturating statistics: index 0 counts resolved ops, index 1 mispredicts.
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = retire;
  assign cnt_inc[1] = retire && out_mispredict_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign cnt_branches    = g_cnt[0].cnt_reg;
  assign cnt_mispredicts = g_cnt[1].cnt_reg;

  assign out_valid       = out_valid_reg;
  assign out_rob_tag     = out_rob_tag_reg;
  assign out_pd          = out_pd_reg;
  assign out_wb_en       = out_wb_en_reg;
  assign out_data        = out_data_reg;
  assign out_taken       = out_taken_reg;
  assign out_mispredict  = out_mispredict_reg;
  assign out_redirect_pc = out_redirect_pc_reg;

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Directed bench for fu_branch_pipe: resolution table, backpressure, flush,
// asynchronous reset and counter saturation on a narrow-counter instance.
module tb_fu_branch_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [31:0] in_pc, in_imm, in_pred_target, ps1_data, ps2_data;
  logic [4:0]  in_rob_tag, rob_head, flush_tag;
  logic [6:0]  in_pd;
  logic        in_pred_taken, flush_valid, out_ready;

  logic        in_ready, out_valid, out_wb_en, out_taken, out_mispredict;
  logic [4:0]  out_rob_tag;
  logic [6:0]  out_pd;
  logic [31:0] out_data, out_redirect_pc;
  logic [15:0] cnt_branches, cnt_mispredicts;

  logic        in_ready2, out_valid2, out_wb_en2, out_taken2, out_mispredict2;
  logic [4:0]  out_rob_tag2;
  logic [6:0]  out_pd2;
  logic [31:0] out_data2, out_redirect_pc2;
  logic [1:0]  cnt_branches2, cnt_mispredicts2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fu_branch_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_pc(in_pc), .in_imm(in_imm),
    .in_rob_tag(in_rob_tag), .in_pd(in_pd), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .ps1_data(ps1_data), .ps2_data(ps2_data),
    .rob_head(rob_head), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_tag(out_rob_tag),
    .out_pd(out_pd), .out_wb_en(out_wb_en), .out_data(out_data),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc), .cnt_branches(cnt_branches),
    .cnt_mispredicts(cnt_mispredicts)
  );

  fu_branch_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_pc(in_pc), .in_imm(in_imm),
    .in_rob_tag(in_rob_tag), .in_pd(in_pd), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .ps1_data(ps1_data), .ps2_data(ps2_data),
    .rob_head(rob_head), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_rob_tag(out_rob_tag2),
    .out_pd(out_pd2), .out_wb_en(out_wb_en2), .out_data(out_data2),
    .out_taken(out_taken2), .out_mispredict(out_mispredict2),
    .out_redirect_pc(out_redirect_pc2), .cnt_branches(cnt_branches2),
    .cnt_mispredicts(cnt_mispredicts2)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1, rs2;
    logic        pt;
    logic [31:0] ptgt;
    logic [6:0]  pd;
    logic [4:0]  tag;
    logic        e_taken, e_mis, e_wb;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [31:0] pc,
                              logic [31:0] imm, logic [31:0] rs1, logic [31:0] rs2,
                              logic pt, logic [31:0] ptgt, logic [6:0] pd,
                              logic [4:0] tag, logic et, logic em, logic ew,
                              logic [31:0] er);
    vec_t v;
    v.op = op; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.pt = pt; v.ptgt = ptgt; v.pd = pd; v.tag = tag;
    v.e_taken = et; v.e_mis = em; v.e_wb = ew; v.e_redir = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_func3 = v.f3; in_pc = v.pc; in_imm = v.imm;
    ps1_data = v.rs1; ps2_data = v.rs2; in_pred_taken = v.pt;
    in_pred_target = v.ptgt; in_pd = v.pd; in_rob_tag = v.tag;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = mk(7'b1100011, 3'b100, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 7'd1, 5'd0, 1, 1, 0, 32'h120);
    vecs[1]  = mk(7'b1100011, 3'b110, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 7'd1, 5'd1, 0, 0, 0, 32'h104);
    vecs[2]  = mk(7'b1100111, 3'b000, 32'h200, 32'h4, 32'h1001, 32'h0, 1, 32'h1004, 7'd9, 5'd2, 1, 0, 1, 32'h1004);
    vecs[3]  = mk(7'b1100011, 3'b000, 32'h300, 32'hFFFFFFF0, 32'h5, 32'h5, 1, 32'h2F0, 7'd3, 5'd3, 1, 0, 0, 32'h2F0);
    vecs[4]  = mk(7'b1100011, 3'b001, 32'h300, 32'hFFFFFFF0, 32'h5, 32'h5, 1, 32'h2F0, 7'd3, 5'd4, 0, 1, 0, 32'h304);
    vecs[5]  = mk(7'b1100011, 3'b101, 32'h400, 32'h8, 32'h80000000, 32'h0, 0, 32'h0, 7'd5, 5'd5, 0, 0, 0, 32'h404);
    vecs[6]  = mk(7'b1100011, 3'b111, 32'h400, 32'h8, 32'h80000000, 32'h0, 1, 32'h40C, 7'd6, 5'd6, 1, 1, 0, 32'h408);
    vecs[7]  = mk(7'b1101111, 3'b000, 32'h500, 32'h11, 32'h0, 32'h0, 0, 32'h0, 7'd7, 5'd7, 1, 1, 1, 32'h511);
    vecs[8]  = mk(7'b1100011, 3'b010, 32'h600, 32'h100, 32'h0, 32'h0, 1, 32'h700, 7'd8, 5'd8, 0, 0, 0, 32'h604);
    vecs[9]  = mk(7'b1100111, 3'b001, 32'h700, 32'h4, 32'h0, 32'h0, 1, 32'h4, 7'd9, 5'd9, 0, 0, 0, 32'h704);
    vecs[10] = mk(7'b1101111, 3'b000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 1, 32'h4, 7'd10, 5'd10, 1, 0, 1, 32'h4);
    vecs[11] = mk(7'b0110011, 3'b000, 32'h800, 32'h0, 32'h1, 32'h2, 1, 32'h0, 7'd11, 5'd11, 0, 0, 0, 32'h804);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_valid = 1'b0;
    flush_tag = '0; rob_head = '0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cnt_br", 32'(cnt_branches), 0);
    chk("rst_redirect", out_redirect_pc, 0);
    $display("reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    @(negedge clk) reset = 1'b0;

    // Single-op resolution table, consumer always ready
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_taken", 32'(out_taken), 32'(vecs[i].e_taken));
      chk("vec_mispredict", 32'(out_mispredict), 32'(vecs[i].e_mis));
      chk("vec_wb_en", 32'(out_wb_en), 32'(vecs[i].e_wb));
      chk("vec_redirect", out_redirect_pc, vecs[i].e_redir);
      chk("vec_data", out_data, vecs[i].pc + 32'd4);
      chk("vec_tag", 32'(out_rob_tag), 32'(vecs[i].tag));
      chk("vec_pd", 32'(out_pd), 32'(vecs[i].pd));
      $display("vec %0d: taken=%0d mis=%0d wb=%0d redirect=%h data=%h",
               i, out_taken, out_mispredict, out_wb_en, out_redirect_pc, out_data);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 0);
    chk("table_cnt_br", 32'(cnt_branches), 9);
    chk("table_cnt_mis", 32'(cnt_mispredicts), 4);
    $display("table counters: branches=%0d mispredicts=%0d", cnt_branches, cnt_mispredicts);

    // Backpressure: op A held for three cycles while op B waits
    @(negedge clk);
    out_ready = 1'b0;
    drive(mk(7'b1100011, 3'b000, 32'h800, 32'h10, 32'h7, 32'h7, 0, 32'h0, 7'd2, 5'd12, 1, 1, 0, 32'h810));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_load_valid", 32'(out_valid), 1);
    @(negedge clk);
    drive(mk(7'b1100011, 3'b001, 32'h900, 32'h10, 32'h7, 32'h7, 0, 32'h0, 7'd3, 5'd13, 0, 0, 0, 32'h904));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_redirect", out_redirect_pc, 32'h810);
      chk("bp_hold_tag", 32'(out_rob_tag), 12);
      chk("bp_hold_cnt", 32'(cnt_branches), 9);
      $display("hold %0d: in_ready=%0d tag=%0d redirect=%h", k, in_ready, out_rob_tag, out_redirect_pc);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("bp_next_tag", 32'(out_rob_tag), 13);
    chk("bp_next_redirect", out_redirect_pc, 32'h904);
    chk("bp_cnt_br", 32'(cnt_branches), 10);
    chk("bp_cnt_mis", 32'(cnt_mispredicts), 5);
    $display("release: tag=%0d branches=%0d mispredicts=%0d", out_rob_tag, cnt_branches, cnt_mispredicts);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_drain_cnt", 32'(cnt_branches), 11);

    // Flush of a held, younger op even with the consumer ready
    @(negedge clk);
    rob_head = 5'd30; out_ready = 1'b0;
    drive(mk(7'b1100011, 3'b000, 32'hA00, 32'h40, 32'h1, 32'h1, 1, 32'hA40, 7'd4, 5'd2, 1, 0, 0, 32'hA40));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("fl_load_valid", 32'(out_valid), 1);
    @(negedge clk);
    in_valid = 1'b0; flush_valid = 1'b1; flush_tag = 5'd31; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("fl_young_killed", 32'(out_valid), 0);
    chk("fl_young_cnt", 32'(cnt_branches), 11);
    $display("flush held tag 2: out_valid=%0d branches=%0d", out_valid, cnt_branches);

    // Held op equal to the flush tag survives
    @(negedge clk);
    flush_valid = 1'b0; out_ready = 1'b0; in_rob_tag = 5'd31; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush_valid = 1'b1; flush_tag = 5'd31;
    @(posedge clk);
    #1;
    chk("fl_equal_survives", 32'(out_valid), 1);
    chk("fl_equal_tag", 32'(out_rob_tag), 31);
    @(negedge clk);
    flush_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("fl_equal_cnt", 32'(cnt_branches), 12);
    $display("flush held tag 31: survived, branches=%0d", cnt_branches);

    // Incoming younger op dropped; in_ready unaffected
    @(negedge clk);
    in_rob_tag = 5'd2; in_valid = 1'b1; flush_valid = 1'b1; flush_tag = 5'd31;
    #1;
    chk("kill_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("kill_in_dropped", 32'(out_valid), 0);
    @(negedge clk);
    in_rob_tag = 5'd31;
    @(posedge clk);
    #1;
    chk("kill_in_equal_loaded", 32'(out_valid), 1);
    @(negedge clk);
    in_valid = 1'b0; flush_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("kill_in_cnt", 32'(cnt_branches), 13);
    $display("incoming flush: branches=%0d", cnt_branches);

    // Asynchronous reset in the middle of a hold
    @(negedge clk);
    rob_head = '0; out_ready = 1'b0;
    drive(mk(7'b1101111, 3'b000, 32'hC00, 32'h20, 32'h0, 32'h0, 0, 32'h0, 7'd5, 5'd0, 1, 1, 1, 32'hC20));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_held_wb", 32'(out_wb_en), 1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_wb", 32'(out_wb_en), 0);
    chk("ar_data", out_data, 0);
    chk("ar_redirect", out_redirect_pc, 0);
    chk("ar_pd", 32'(out_pd), 0);
    chk("ar_cnt_br", 32'(cnt_branches), 0);
    chk("ar_cnt_mis", 32'(cnt_mispredicts), 0);
    $display("async reset: out_valid=%0d data=%h branches=%0d", out_valid, out_data, cnt_branches);
    @(negedge clk) reset = 1'b0;

    // Five mispredicted BNEs: 2-bit counters saturate, 16-bit ones do not
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(mk(7'b1100011, 3'b001, 32'hD00, 32'h8, 32'h3, 32'h3, 1, 32'hD08, 7'd6, 5'(k), 0, 1, 0, 32'hD04));
      in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_cnt_br", 32'(cnt_branches2), 3);
    chk("sat_cnt_mis", 32'(cnt_mispredicts2), 3);
    chk("wide_cnt_br", 32'(cnt_branches), 5);
    chk("wide_cnt_mis", 32'(cnt_mispredicts), 5);
    $display("saturation: narrow=%0d/%0d wide=%0d/%0d",
             cnt_branches2, cnt_mispredicts2, cnt_branches, cnt_mispredicts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
